// File: rtl/unsigned_16by8_div_seq_if.sv
// unsigned_16by8_div_seq_if
// Purpose : bundles the operand handshake (in_valid/in_ready, x, y) and the
//           result handshake (out_valid/out_ready, z, r, optional err) of
//           the sequential 16-by-8 unsigned divider.
// Modports: master - the operand producer / result consumer
//           slave  - the divider itself
// Macro   : DIV_ERR_FLAG_EN adds the err signal (divide-by-zero flag).
interface unsigned_16by8_div_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [7:0]  y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] z;
    logic [7:0]  r;
`ifdef DIV_ERR_FLAG_EN
    logic        err;
`endif

    // The producer drives operands and the downstream ready; it observes
    // the divider's ready, valid and results.
    modport master (
        output in_valid, x, y, out_ready,
`ifdef DIV_ERR_FLAG_EN
        input  in_ready, out_valid, z, r, err
`else
        input  in_ready, out_valid, z, r
`endif
    );

    // The divider sees the mirror image of the producer.
    modport slave (
        input  in_valid, x, y, out_ready,
`ifdef DIV_ERR_FLAG_EN
        output in_ready, out_valid, z, r, err
`else
        output in_ready, out_valid, z, r
`endif
    );
endinterface

// File: rtl/unsigned_16by8_div_seq.sv
// unsigned_16by8_div_seq
// Purpose : sequential restoring divider, 16-bit unsigned dividend by 8-bit
//           unsigned divisor, one quotient bit per clock.
// Ports   : clk - rising-edge clock
//           rst - asynchronous active-high reset
//           bus - unsigned_16by8_div_seq_if.slave
//                 in_valid/in_ready/x/y   operand handshake
//                 out_valid/out_ready/z/r result handshake (z=x/y, r=x%y)
//                 err                     captured y==0 (only with macro)
// Param   : LAT_CYC - number of BUSY iterations; only 16 is supported.
// Macro   : DIV_ERR_FLAG_EN - when defined, adds the registered err output.
// Timing  : operands are accepted on an edge in IDLE; the 16 following
//           edges each retire one quotient bit, and the next edge enters
//           DONE with the result, so out_valid is first seen 17 edges
//           after the accepting edge.
module unsigned_16by8_div_seq #(
    parameter int LAT_CYC = 16
) (
    input logic                      clk,
    input logic                      rst,
    unsigned_16by8_div_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_ITER = 4'(LAT_CYC - 1);

    state_t      state_q;
    state_t      state_d;
    logic        in_ready;
    logic        out_valid;
    logic        accept;

    logic [15:0] dvd_q;
    logic [7:0]  dvs_q;
    logic [7:0]  rem_q;
    logic [3:0]  iter_cnt_q;
    logic        iter_done_q;
    logic [15:0] z_q;
    logic [7:0]  r_q;
`ifdef DIV_ERR_FLAG_EN
    logic        err_q;
`endif

    logic [8:0]  trial;
    logic [9:0]  diff;
    logic        q_bit;
    logic [7:0]  rem_next;
    logic [15:0] dvd_next;
    logic        diff_msb_unused;

    // One restoring-division step. The 9-bit trial is the partial
    // remainder shifted left with the next dividend bit (MSB first) brought
    // in; the extra top bit of diff is the borrow. When there is no borrow
    // the subtraction is kept and the quotient bit is 1. dvd_q doubles as
    // the quotient register: dividend bits leave at the top while quotient
    // bits enter at the bottom. For a zero divisor every step "succeeds",
    // giving an all-ones quotient and the low dividend byte as remainder,
    // with no special timing.
    always_comb begin
        trial    = {rem_q, dvd_q[15]};
        diff     = {1'b0, trial} - {2'b00, dvs_q};
        q_bit    = ~diff[9];
        rem_next = trial[7:0];
        if (q_bit) begin
            rem_next = diff[7:0];
        end
        dvd_next = {dvd_q[14:0], q_bit};
    end

    // Bit 8 of the difference is only meaningful for a zero divisor, where
    // it is intentionally dropped as the remainder is only 8 bits wide.
    assign diff_msb_unused = diff[8];

    // State register; reset always lands in IDLE so any operation in
    // flight is abandoned without producing a result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs. Ready is only offered in IDLE, so a
    // result handshake and a new accept can never share an edge.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (iter_done_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign accept = (state_q == IDLE) && bus.in_valid;

    // Datapath registers. Operands are captured only on an accept, so the
    // inputs are ignored while busy or holding a result. The iteration
    // counter wraps from 15 back to 0 on the sixteenth step, which is when
    // iter_done_q is raised; the following BUSY edge commits the finished
    // quotient and remainder into the output registers as DONE is entered.
    // z/r keep their values through IDLE until the next result lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            iter_cnt_q  <= '0;
            iter_done_q <= 1'b0;
            z_q         <= '0;
            r_q         <= '0;
`ifdef DIV_ERR_FLAG_EN
            err_q       <= 1'b0;
`endif
        end else if (accept) begin
            dvd_q       <= bus.x;
            dvs_q       <= bus.y;
            rem_q       <= '0;
            iter_cnt_q  <= '0;
            iter_done_q <= 1'b0;
        end else if (state_q == BUSY) begin
            if (!iter_done_q) begin
                dvd_q      <= dvd_next;
                rem_q      <= rem_next;
                iter_cnt_q <= iter_cnt_q + 4'd1;
                if (iter_cnt_q == LAST_ITER) begin
                    iter_done_q <= 1'b1;
                end
            end else begin
                z_q <= dvd_q;
                r_q <= rem_q;
`ifdef DIV_ERR_FLAG_EN
                err_q <= (dvs_q == 8'd0);
`endif
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.z         = z_q;
    assign bus.r         = r_q;
`ifdef DIV_ERR_FLAG_EN
    assign bus.err       = err_q;
`endif

endmodule

// File: tb/tb_unsigned_16by8_div_seq.sv
// tb_unsigned_16by8_div_seq
// Purpose : directed self-checking bench for unsigned_16by8_div_seq.
//           Covers reset values, a table of divisions with hand-computed
//           quotient/remainder, latency, backpressure in DONE, and a reset
//           in the middle of an operation.
// Macro   : DIV_ERR_FLAG_EN - when defined, err is checked as well.
module tb_unsigned_16by8_div_seq;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    unsigned_16by8_div_seq_if bus ();

    unsigned_16by8_div_seq #(
        .LAT_CYC(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Every comparison goes through here so the counters stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                     tag, observed, observed, expected, expected);
        end
    endtask

    // Present one operand pair for exactly one accepting edge, then
    // scramble the inputs so any late sampling would corrupt the result.
    task automatic applyStimulus(input logic [15:0] xv, input logic [7:0] yv);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x        = xv;
        bus.y        = yv;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.x        = ~xv;
        bus.y        = ~yv;
        checkOutput("accept_in_ready", {31'd0, bus.in_ready}, 32'd0);
    endtask

    // Count edges after the accepting edge until out_valid, bounded.
    task automatic waitResult(output int cyc);
        cyc = 0;
        while (cyc < 40 && !bus.out_valid) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Pulse out_ready for one edge and confirm the return to IDLE.
    task automatic releaseResult(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput({tag, "_idle_valid"}, {31'd0, bus.out_valid}, 32'd0);
        checkOutput({tag, "_idle_ready"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic runDivide(input string tag, input logic [15:0] xv,
                             input logic [7:0] yv, input logic [15:0] ez,
                             input logic [7:0] er, input logic eerr);
        int cyc;
        applyStimulus(xv, yv);
        waitResult(cyc);
        checkOutput({tag, "_latency"}, cyc, 32'd17);
        checkOutput({tag, "_z"}, {16'd0, bus.z}, {16'd0, ez});
        checkOutput({tag, "_r"}, {24'd0, bus.r}, {24'd0, er});
`ifdef DIV_ERR_FLAG_EN
        checkOutput({tag, "_err"}, {31'd0, bus.err}, {31'd0, eerr});
`else
        if (eerr !== 1'b0 && eerr !== 1'b1) begin
            $display("[TB] bad vector %s", tag);
        end
`endif
        releaseResult(tag);
        checkOutput({tag, "_z_held"}, {16'd0, bus.z}, {16'd0, ez});
    endtask

    localparam int NVEC = 6;
    logic [15:0] vec_x  [NVEC] = '{16'd1000, 16'd65535, 16'd65535, 16'd5,  16'd0,   16'd1234};
    logic [7:0]  vec_y  [NVEC] = '{8'd7,     8'd255,    8'd1,      8'd9,   8'd200,  8'd0};
    logic [15:0] vec_z  [NVEC] = '{16'd142,  16'd257,   16'd65535, 16'd0,  16'd0,   16'hFFFF};
    logic [7:0]  vec_r  [NVEC] = '{8'd6,     8'd0,      8'd0,      8'd5,   8'd0,    8'hD2};
    logic        vec_e  [NVEC] = '{1'b0,     1'b0,      1'b0,      1'b0,   1'b0,    1'b1};

    initial begin
        int  cyc;
        bit  seen;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("reset_z", {16'd0, bus.z}, 32'd0);
        checkOutput("reset_r", {24'd0, bus.r}, 32'd0);
`ifdef DIV_ERR_FLAG_EN
        checkOutput("reset_err", {31'd0, bus.err}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            runDivide($sformatf("vec%0d", i), vec_x[i], vec_y[i],
                      vec_z[i], vec_r[i], vec_e[i]);
        end

        // Backpressure: 40000/123 = 325 rem 25, held for 10 cycles while a
        // competing operand pair is offered and must be ignored.
        applyStimulus(16'd40000, 8'd123);
        waitResult(cyc);
        checkOutput("bp_latency", cyc, 32'd17);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x        = 16'd7;
        bus.y        = 8'd2;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_valid", {31'd0, bus.out_valid}, 32'd1);
            checkOutput("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            checkOutput("bp_z", {16'd0, bus.z}, 32'd325);
            checkOutput("bp_r", {24'd0, bus.r}, 32'd25);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_still_idle", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("bp_z_kept", {16'd0, bus.z}, 32'd325);

        // Reset during the eighth BUSY cycle: nothing may come out.
        applyStimulus(16'd500, 8'd7);
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("midrst_z", {16'd0, bus.z}, 32'd0);
        checkOutput("midrst_r", {24'd0, bus.r}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                seen = 1'b1;
            end
        end
        checkOutput("midrst_no_result", {31'd0, seen}, 32'd0);

        // Reset again and offer 100/3 on the very first edge after release.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b1;
        bus.x        = 16'd100;
        bus.y        = 8'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.x        = 16'hAAAA;
        bus.y        = 8'h55;
        checkOutput("postrst_accept", {31'd0, bus.in_ready}, 32'd0);
        waitResult(cyc);
        checkOutput("postrst_latency", cyc, 32'd17);
        checkOutput("postrst_z", {16'd0, bus.z}, 32'd33);
        checkOutput("postrst_r", {24'd0, bus.r}, 32'd1);
        releaseResult("postrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/unsigned_16by8_div_seq.md
UNSIGNED_16BY8_DIV_SEQ -- requirements
Module: unsigned_16by8_div_seq

Interface
REQ-001 SHALL have parameter LAT_CYC, default 16, meaning the number of BUSY iterations; it is fixed at 16 (one quotient bit per cycle), and any other value is unsupported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1, meaning operands are presented.
REQ-005 SHALL have port in_ready, output, 1, meaning the block can accept operands.
REQ-006 SHALL have port x, input, 16, the unsigned dividend.
REQ-007 SHALL have port y, input, 8, the unsigned divisor.
REQ-008 SHALL have port out_valid, output, 1, meaning the result is held.
REQ-009 SHALL have port out_ready, input, 1, meaning the downstream consumer takes the result.
REQ-010 SHALL have port z, output, 16, the quotient floor(x/y).
REQ-011 SHALL have port r, output, 8, the remainder x mod y.
REQ-012 SHALL have port err, output, 1, only when DIV_ERR_FLAG_EN is defined (see Configuration).

Function
REQ-013 SHALL implement states IDLE, BUSY and DONE, one-hot or encoded, with no other reachable states.
REQ-014 SHALL, in IDLE, drive in_ready=1 and out_valid=0, and on in_valid&&in_ready capture x and y into internal registers and go to BUSY.
REQ-015 SHALL, in BUSY, run restoring division: shift the 9-bit partial remainder left, bring in the next dividend bit (MSB first), subtract the zero-extended divisor when no borrow occurs, and set the quotient bit to 1 on success, else 0.
REQ-016 SHALL hold BUSY for exactly 16 cycles, counted by a 4-bit iteration counter that wraps from 15 to 0, and SHALL then go to DONE.
REQ-017 SHALL, in DONE, assert out_valid with z and r stable until out_valid&&out_ready, then return to IDLE.
REQ-018 SHALL place the result exactly 17 cycles after the accepting edge (the accepting edge being cycle 0): 16 BUSY cycles plus one DONE entry.
REQ-019 SHALL drive in_ready=0 in BUSY and DONE; no new operand is accepted until the DONE handshake completes, so there is no same-cycle accept-and-complete.
REQ-020 SHALL change captured operands only at an accept; input changes during BUSY or DONE SHALL have no effect.
REQ-021 SHALL, for y==0, produce z=16'hFFFF and r=x[7:0] with normal latency; this falls out of the datapath and needs no special-case timing.
REQ-022 SHALL keep r less than y for every y!=0, and z*y+r==x for all operand pairs with y!=0.
REQ-023 SHALL hold z and r at their last values in IDLE (0 after reset).

Reset
REQ-024 SHALL, on rst=1 at any time, asynchronously force IDLE, in_ready=1, out_valid=0, z=0, r=0, iteration counter=0 and err=0.
REQ-025 SHALL discard any operation in progress when rst asserts mid-BUSY or mid-DONE, with no result emitted.
REQ-026 SHALL accept in_valid on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL, with macro DIV_ERR_FLAG_EN defined, provide output err, registered with z, equal to 1 when the captured y==0 and 0 otherwise, valid while out_valid=1.
REQ-028 SHALL, without DIV_ERR_FLAG_EN, omit port err and its register; all other behaviour SHALL be identical.

Verification
REQ-029 SHALL cover: x=1000, y=7 -> after 17 cycles out_valid=1, z=142, r=6.
REQ-030 SHALL cover: x=65535, y=255 -> z=257, r=0; and x=65535, y=1 -> z=65535, r=0.
REQ-031 SHALL cover: x=5, y=9 -> z=0, r=5; and x=0, y=200 -> z=0, r=0.
REQ-032 SHALL cover: x=1234, y=0 -> z=16'hFFFF, r=8'hD2, err=1 when DIV_ERR_FLAG_EN is defined.
REQ-033 SHALL cover backpressure: out_ready held at 0 for 10 cycles in DONE -> z and r stable, in_ready=0, and a new in_valid is ignored; the pulse of out_ready -> IDLE on the next cycle.
REQ-034 SHALL cover reset mid-operation: rst at BUSY cycle 8 -> out_valid never asserts; a following x=100, y=3 -> z=33, r=1.
